// File: rtl/vga_board_arbiter.sv
// Board RAM arbiter: scan-out > clear > game (read/write round-robin).
// Scan and game reads return data two cycles after the request edge.
module vga_board_arbiter #(
  parameter int CELLS          = 200,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 3,
  parameter bit WR_VBLANK_ONLY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

  logic              in_flight;
  logic              last_wr;
  logic [ADDR_W-1:0] clr_idx;
  logic              t1_scan, t1_rd, t1_oor;
  logic              t2_scan, t2_rd, t2_oor;

  logic wr_gate, game_ok, rd_elig, wr_elig;
  logic clr_go, rd_win, wr_win;
  logic scan_oor, rd_oor, wr_oor;

  // Slot eligibility and round-robin choice between game ports
  always_comb begin
    wr_gate  = WR_VBLANK_ONLY ? vblank : 1'b1;
    game_ok  = !scan_req && !clr_busy;
    rd_elig  = game_ok && rd_req && !in_flight && !rd_ack;
    wr_elig  = game_ok && wr_req && !wr_ack && wr_gate;
    clr_go   = !scan_req && clr_busy && wr_gate;
    rd_win   = rd_elig && (!wr_elig || last_wr);
    wr_win   = wr_elig && !rd_win;
    scan_oor = {1'b0, scan_addr} >= LIMIT;
    rd_oor   = {1'b0, rd_addr} >= LIMIT;
    wr_oor   = {1'b0, wr_addr} >= LIMIT;
  end

  // Grant one RAM slot per cycle and drive the registered RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      clr_idx   <= '0;
      in_flight <= 1'b0;
      last_wr   <= 1'b1;
      t1_scan   <= 1'b0;
      t1_rd     <= 1'b0;
      t1_oor    <= 1'b0;
    end else begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      clr_done  <= 1'b0;
      t1_scan   <= 1'b0;
      t1_rd     <= 1'b0;
      t1_oor    <= 1'b0;
      if (t2_rd)
        in_flight <= 1'b0;
      if (scan_req) begin
        mem_addr <= scan_addr;
        t1_scan  <= 1'b1;
        t1_oor   <= scan_oor;
      end else if (clr_go) begin
        mem_addr <= clr_idx;
        mem_we   <= 1'b1;
        clr_idx  <= clr_idx + 1'b1;
        if (clr_idx == LAST) begin
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
          clr_idx  <= '0;
        end
      end else if (rd_win) begin
        mem_addr  <= rd_addr;
        t1_rd     <= 1'b1;
        t1_oor    <= rd_oor;
        in_flight <= 1'b1;
        last_wr   <= 1'b0;
      end else if (wr_win) begin
        mem_addr  <= wr_addr;
        mem_we    <= !wr_oor;
        mem_wdata <= wr_oor ? '0 : wr_data;
        wr_ack    <= 1'b1;
        last_wr   <= 1'b1;
      end
      if (!clr_busy && clr_req) begin
        clr_busy <= 1'b1;
        clr_idx  <= '0;
      end
    end
  end

  // Return path: wait out the RAM latency, then present read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t2_scan    <= 1'b0;
      t2_rd      <= 1'b0;
      t2_oor     <= 1'b0;
      scan_valid <= 1'b0;
      scan_data  <= '0;
      rd_ack     <= 1'b0;
      rd_data    <= '0;
    end else begin
      t2_scan    <= t1_scan;
      t2_rd      <= t1_rd;
      t2_oor     <= t1_oor;
      scan_valid <= t2_scan;
      scan_data  <= (t2_scan && !t2_oor) ? mem_rdata : '0;
      rd_ack     <= t2_rd;
      rd_data    <= (t2_rd && !t2_oor) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_board_arbiter.sv
// Bench for vga_board_arbiter: board RAM model plus scoreboard queues
// for scan fetches, game reads and RAM writes.
module tb_vga_board_arbiter;

  localparam int CELLS = 200;

  typedef struct {
    int data;
    int due;
  } rd_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vblank = 1'b0;
  logic       scan_req = 1'b0;
  logic [7:0] scan_addr = '0;
  logic       scan_valid;
  logic [2:0] scan_data;
  logic       clr_req = 1'b0;
  logic       clr_busy;
  logic       clr_done;
  logic       rd_req = 1'b0;
  logic [7:0] rd_addr = '0;
  logic       rd_ack;
  logic [2:0] rd_data;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [2:0] wr_data = '0;
  logic       wr_ack;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata = '0;

  logic [2:0] ram [256];

  rd_t sq[$];
  rd_t rq[$];
  wr_t wq[$];
  rd_t se, re;
  wr_t we;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  vga_board_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblank    (vblank),
    .scan_req  (scan_req),
    .scan_addr (scan_addr),
    .scan_valid(scan_valid),
    .scan_data (scan_data),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Synchronous single-port board RAM, read-first
  always @(posedge clk) begin
    if (mem_we)
      ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pop scoreboard entries as results appear
  always @(posedge clk) begin
    #1;
    if (scan_valid) begin
      if (sq.size() > 0) begin
        se = sq.pop_front();
        chk("scan_data", 32'(scan_data), se.data);
        if (se.due >= 0)
          chk("scan_lat", cyc, se.due);
      end else
        chk("scan_extra", sq.size(), 1);
    end
    if (rd_ack) begin
      rd_cnt++;
      if (rq.size() > 0) begin
        re = rq.pop_front();
        chk("rd_data", 32'(rd_data), re.data);
      end else
        chk("rd_extra", rq.size(), 1);
    end
    if (mem_we) begin
      if (wq.size() > 0) begin
        we = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), we.addr);
        chk("wr_data", 32'(mem_wdata), we.data);
      end else
        chk("we_extra", wq.size(), 1);
    end
    if (!mem_we && mem_wdata != 3'd0)
      chk("wdata_idle", 32'(mem_wdata), 0);
    if (wr_ack)
      wr_cnt++;
    if (clr_done) begin
      done_cnt++;
      chk("done_addr", 32'(mem_addr), CELLS - 1);
      chk("done_we", 32'(mem_we), 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    string pat;
    int    rd0, wr0, d0, k;
    logic  [7:0] slot;

    for (int i = 0; i < 256; i++)
      ram[i] = 3'(i % 8);

    // Reset state
    #3;
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_outs", {scan_valid, rd_ack, wr_ack, clr_done}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_we_cnt", wr_cnt + rd_cnt + done_cnt, 0);

    // Back-to-back scan fetches of preloaded cells
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      scan_req = 1'b1;
      scan_addr = 8'(i);
      sq.push_back('{i % 8, cyc + 3});
    end
    @(negedge clk);
    scan_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("scan_drain", sq.size(), 0);

    // Game write held off until vblank
    wr_req = 1'b1;
    wr_addr = 8'd5;
    wr_data = 3'd6;
    repeat (10) @(negedge clk);
    chk("wr_gated", wr_cnt, 0);
    wq.push_back('{5, 6});
    vblank = 1'b1;
    @(posedge clk);
    #1;
    chk("wr_ack_vb", 32'(wr_ack), 1);
    chk("wr_we_vb", 32'(mem_we), 1);
    @(negedge clk);
    wr_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("wr_once", wr_cnt, 1);

    // Round-robin with both game ports held
    pat = "RW-WRW-WRW-W";
    rd_addr = 8'd20;
    wr_addr = 8'd30;
    wr_data = 3'd3;
    for (int i = 0; i < 3; i++) rq.push_back('{4, -1});
    for (int i = 0; i < 6; i++) wq.push_back('{30, 3});
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (mem_we && mem_addr == 8'd30) slot = "W";
      else if (mem_addr == 8'd20) slot = "R";
      else slot = "-";
      chk($sformatf("rr_slot%0d", i), 32'(slot), 32'(pat[i]));
    end
    @(negedge clk);
    rd_req = 1'b0;
    wr_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rr_rd_cnt", rd_cnt, 3);
    chk("rr_q", rq.size() + wq.size(), 0);

    // Board clear interleaved with scan, game ports blocked
    for (int i = 0; i < CELLS; i++) wq.push_back('{i, 0});
    d0 = done_cnt;
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    chk("clr_busy_set", 32'(clr_busy), 1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    rd_req = 1'b1;
    rd_addr = 8'd40;
    wr_req = 1'b1;
    wr_addr = 8'd41;
    wr_data = 3'd5;
    k = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
      scan_req = n[0];
      scan_addr = 8'd255;
      if (n[0]) begin
        sq.push_back('{0, cyc + 3});
        k++;
      end
    end
    scan_req = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    chk("clr_done_cnt", done_cnt - d0, 1);
    chk("clr_busy_drop", 32'(clr_busy), 0);
    chk("clr_game_rd", rd_cnt, rd0);
    chk("clr_game_wr", wr_cnt, wr0);
    repeat (5) @(negedge clk);
    chk("clr_wq", wq.size(), 0);
    chk("clr_sq", sq.size(), 0);
    chk("clr_scans", k > 150, 1);

    // Out-of-range accesses, and cleared cells read back as 0
    scan_req = 1'b1;
    scan_addr = 8'd220;
    sq.push_back('{0, cyc + 3});
    @(negedge clk);
    scan_addr = 8'd5;
    sq.push_back('{0, cyc + 3});
    @(negedge clk);
    scan_addr = 8'd30;
    sq.push_back('{0, cyc + 3});
    @(negedge clk);
    scan_req = 1'b0;
    wr_req = 1'b1;
    wr_addr = 8'd210;
    wr_data = 3'd7;
    @(posedge clk);
    #1;
    chk("oor_wr_ack", 32'(wr_ack), 1);
    chk("oor_wr_we", 32'(mem_we), 0);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b1;
    rd_addr = 8'd230;
    rq.push_back('{0, -1});
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #2;
      if (rd_ack) break;
    end
    chk("oor_rd_ack", 32'(rd_ack), 1);
    @(negedge clk);
    rd_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("oor_q", sq.size() + rq.size(), 0);

    // Reset with a read in flight
    rd0 = rd_cnt;
    rd_req = 1'b1;
    rd_addr = 8'd7;
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rd_addr", 32'(mem_addr), 7);
    chk("abort_busy", 32'(clr_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {mem_addr, mem_we, clr_busy}, 0);
    @(negedge clk);
    rd_req = 1'b0;
    clr_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_ack", rd_cnt, rd0);

    // Reset at clear index 100
    for (int i = 0; i < 100; i++) wq.push_back('{i, 0});
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #2;
      if (wq.size() == 0) break;
    end
    chk("mid_wq", wq.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_outs", {mem_addr, mem_we, mem_wdata, clr_busy}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(clr_busy), 0);
    chk("mid_wq_end", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_board_arbiter.md
# vga_board_arbiter

Arbitrates the single-port, synchronous board RAM (10×20 Tetris cells, 3-bit colour code each) between three requesters:
- the VGA scan-out cell fetch;
- a board-clear sequencer;
- the game logic's read and write ports.

Scan-out has absolute priority so the display never misses a fetch. Game writes can be held off until vertical blank for tear-free updates. The block sits between the VGA pixel pipeline, the game FSM and the board RAM.

## Interface
Parameters:
- CELLS, 200, number of valid board cells (addresses 0..CELLS-1)
- ADDR_W, 8, address width
- DATA_W, 3, cell data width
- WR_VBLANK_ONLY, 1, 1 = game writes and clear writes granted only while vblank=1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- vblank  in  1  high during vertical blanking (synchronous to clk)
- scan_req  in  1  scan-out fetch request, single-cycle, may repeat every cycle
- scan_addr  in  ADDR_W  fetch address, valid with scan_req
- scan_valid  out  1  scan_data valid (one-cycle pulse per request)
- scan_data  out  DATA_W  fetched cell
- clr_req  in  1  start board clear (pulse)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse at clear completion
- rd_req  in  1  game read request, held until rd_ack
- rd_addr  in  ADDR_W  game read address, stable while rd_req
- rd_ack  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DATA_W  game read data
- wr_req  in  1  game write request, held until wr_ack
- wr_addr  in  ADDR_W  game write address, stable while wr_req
- wr_data  in  DATA_W  game write data, stable while wr_req
- wr_ack  out  1  one-cycle pulse, write issued
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- One RAM access slot per clk. Grant priority: scan > clear > game. The game read and write ports share the game slot round-robin.
- Round-robin pointer resets to "last served = write", so read wins the first tie. The pointer updates only on a game grant.
- Game write eligible: wr_req=1 and wr_ack=0. If WR_VBLANK_ONLY=1, vblank=1 is also required.
- Game read eligible: rd_req=1, no read in flight, and rd_ack=0. vblank is ignored for reads.
- While clr_busy=1, both game ports are ineligible.
- Clear:
  - clr_req sampled while clr_busy=0 sets clr_busy and an internal index to 0.
  - Each slot not taken by scan, and passing the vblank gate when WR_VBLANK_ONLY=1, writes 0 to the index and increments it.
  - After the write to CELLS-1, clr_busy drops and clr_done pulses on the same edge.
  - clr_req while clr_busy=1 is ignored.
- Out-of-range addresses (≥CELLS):
  - Scan and game reads return 0 but still take the slot.
  - Game writes are acked with mem_we=0.
- Scan starvation of the game ports is permitted; game traffic is served in scan gaps (horizontal and vertical blank).

## Timing
- Reset: every output is 0, the clear index is 0, no read is in flight, and the RR pointer is "write".
- Request sampled at edge E0; mem_addr/mem_we/mem_wdata are driven after E0.
- Write: wr_ack pulses in the same cycle mem_we=1 (after E0).
- Scan read: scan_valid and scan_data are driven after E2, i.e. 2-cycle latency. Back-to-back scan_req produce back-to-back scan_valid, in order.
- Game read: rd_ack and rd_data are driven after E2. A new read is not granted before rd_ack.
- mem_we is low in every cycle not carrying a clear write or an in-range game write. mem_wdata=0 when mem_we=0.
- rst_n low mid-operation: in-flight reads are dropped (no ack or valid), the clear is aborted, and all outputs go to 0 asynchronously.

## Test plan
- Reset release: all outputs 0; idle clk cycles produce mem_we=0 and no pulses.
- RAM preloaded with cell n = n mod 8; scan_req on 4 consecutive cycles with addr 0..3 → scan_valid on 4 consecutive cycles starting 2 cycles later, data 0,1,2,3.
- WR_VBLANK_ONLY=1, wr_req addr 5 data 6 held with vblank=0 for 10 cycles → no wr_ack. Raise vblank → wr_ack and mem_we (addr 5, data 6) one cycle later, exactly once.
- rd_req and wr_req both held, vblank=1, no scan, requester re-requesting after each ack → grants alternate read, write, read…; a read is not re-granted until its rd_ack.
- clr_req with vblank=1 and scan_req every 2nd cycle → 200 writes of 0 to addresses 0..199 in order, interleaved with scan fetches; clr_done pulses once and clr_busy drops. Game requests during the clear are not acked.
- rst_n asserted at clear index 100 with a read in flight → outputs 0 immediately, no rd_ack. After release, mem_we stays 0 and clr_busy stays 0.
